// File: rtl/mem_port_arbiter_if.sv
// Requester and RAM-side signal bundle for mem_port_arbiter.
// slave is the arbiter's view; master is the requesters plus the RAM.
interface mem_port_arbiter_if;
  logic        fetch_req;
  logic [8:0]  fetch_addr;
  logic        fetch_ack;
  logic        fetch_err;
  logic        data_req;
  logic        data_rw;
  logic [8:0]  data_addr;
  logic [1:0]  data_size;
  logic [31:0] data_wdata;
  logic        data_ack;
  logic        data_err;
  logic [31:0] rdata;
  logic        busy;
  logic        ram_mfa;
  logic        ram_rw;
  logic [8:0]  ram_addr;
  logic [1:0]  ram_size;
  logic [31:0] ram_din;
  logic [31:0] ram_dout;
  logic        ram_mfc;

  modport slave (
    input  fetch_req, fetch_addr, data_req, data_rw, data_addr, data_size, data_wdata,
    input  ram_dout, ram_mfc,
    output fetch_ack, fetch_err, data_ack, data_err, rdata, busy,
    output ram_mfa, ram_rw, ram_addr, ram_size, ram_din
  );

  modport master (
    output fetch_req, fetch_addr, data_req, data_rw, data_addr, data_size, data_wdata,
    output ram_dout, ram_mfc,
    input  fetch_ack, fetch_err, data_ack, data_err, rdata, busy,
    input  ram_mfa, ram_rw, ram_addr, ram_size, ram_din
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-requester (fetch/data) round-robin arbiter onto a single RAM port,
// with alignment checking and a bounded wait for ram_mfc.
module mem_port_arbiter #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic              Clk,
  input  logic              reset,
  mem_port_arbiter_if.slave bus
);

  localparam int unsigned CNT_W     = 8;
  localparam int unsigned ADDR_W    = 9;
  localparam int unsigned DATA_W    = 32;
  localparam logic [1:0]  SIZE_WORD = 2'b10;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t             state;
  logic               last_gnt;   // 0 = fetch, 1 = data
  logic               cur_id;
  logic               cur_rw;
  logic [CNT_W-1:0]   cnt;

  logic               gnt_c;
  logic               gnt_id_c;
  logic               g_rw_c;
  logic [ADDR_W-1:0]  g_addr_c;
  logic [1:0]         g_size_c;
  logic [DATA_W-1:0]  g_wdata_c;
  logic               g_legal_c;

  // Pick the winner and form its (fetch-normalised) command and legality
  always_comb begin
    gnt_c    = bus.fetch_req | bus.data_req;
    gnt_id_c = (bus.fetch_req && bus.data_req) ? ~last_gnt : bus.data_req;
    if (gnt_id_c) begin
      g_rw_c    = bus.data_rw;
      g_addr_c  = bus.data_addr;
      g_size_c  = bus.data_size;
      g_wdata_c = bus.data_wdata;
    end else begin
      g_rw_c    = 1'b1;
      g_addr_c  = bus.fetch_addr;
      g_size_c  = SIZE_WORD;
      g_wdata_c = '0;
    end
    case (g_size_c)
      2'b00:   g_legal_c = 1'b1;
      2'b01:   g_legal_c = ~g_addr_c[0];
      2'b10:   g_legal_c = (g_addr_c[1:0] == 2'b00);
      default: g_legal_c = 1'b0;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (reset) begin
      state         <= IDLE;
      last_gnt      <= 1'b1;
      cur_id        <= 1'b0;
      cur_rw        <= 1'b0;
      cnt           <= '0;
      bus.busy      <= 1'b0;
      bus.fetch_ack <= 1'b0;
      bus.fetch_err <= 1'b0;
      bus.data_ack  <= 1'b0;
      bus.data_err  <= 1'b0;
      bus.rdata     <= '0;
      bus.ram_mfa   <= 1'b0;
      bus.ram_rw    <= 1'b0;
      bus.ram_addr  <= '0;
      bus.ram_size  <= '0;
      bus.ram_din   <= '0;
    end else begin
      // ack/err are single-cycle pulses raised only on entry to DONE
      bus.fetch_ack <= 1'b0;
      bus.fetch_err <= 1'b0;
      bus.data_ack  <= 1'b0;
      bus.data_err  <= 1'b0;
      case (state)
        IDLE: begin
          if (gnt_c) begin
            cur_id   <= gnt_id_c;
            cur_rw   <= g_rw_c;
            cnt      <= '0;
            bus.busy <= 1'b1;
            if (g_legal_c) begin
              state        <= BUSY;
              bus.ram_mfa  <= 1'b1;
              bus.ram_rw   <= g_rw_c;
              bus.ram_addr <= g_addr_c;
              bus.ram_size <= g_size_c;
              bus.ram_din  <= g_wdata_c;
            end else begin
              state    <= DONE;
              last_gnt <= gnt_id_c;
              if (gnt_id_c) begin
                bus.data_ack <= 1'b1;
                bus.data_err <= 1'b1;
              end else begin
                bus.fetch_ack <= 1'b1;
                bus.fetch_err <= 1'b1;
              end
            end
          end
        end
        BUSY: begin
          if (bus.ram_mfc || (cnt == CNT_W'(TIMEOUT - 1))) begin
            state       <= DONE;
            bus.ram_mfa <= 1'b0;
            last_gnt    <= cur_id;
            if (bus.ram_mfc && cur_rw) bus.rdata <= bus.ram_dout;
            if (cur_id) begin
              bus.data_ack <= 1'b1;
              bus.data_err <= ~bus.ram_mfc;
            end else begin
              bus.fetch_ack <= 1'b1;
              bus.fetch_err <= ~bus.ram_mfc;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DONE: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
        end
        default: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: expected completions are queued at
// request time and checked against each ack, with a reactive RAM model.
module tb_mem_port_arbiter;
  localparam int TO = 15;

  logic Clk = 1'b0;
  logic reset;

  mem_port_arbiter_if bus();

  mem_port_arbiter #(.TIMEOUT(TO)) dut (
    .Clk   (Clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic        id;
    logic        err;
    logic [31:0] rdata;
    int          lat;
    int          t0;
    int          mfa;
    logic        rw;
    logic [8:0]  addr;
    logic [1:0]  size;
    logic [31:0] din;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          n_vec = 0;
  int          n_err = 0;
  int          cyc = 0;
  logic [31:0] exp_rdata = 32'h0;
  logic [31:0] dout_val = 32'h0;
  int          mfc_delay = 1;
  logic        mfc_r = 1'b0;
  logic        mfc_force = 1'b0;
  int          mfa_run = 0;
  int          mfa_total = 0;
  int          mfa_mark = 0;
  int          ack_total = 0;
  logic        snap_rw;
  logic [8:0]  snap_addr;
  logic [1:0]  snap_size;
  logic [31:0] snap_din;

  assign bus.ram_mfc  = mfc_r | mfc_force;
  assign bus.ram_dout = dout_val;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic is_legal(input logic [1:0] size, input logic [8:0] addr);
    case (size)
      2'b00:   return 1'b1;
      2'b01:   return !addr[0];
      2'b10:   return addr[1:0] == 2'b00;
      default: return 1'b0;
    endcase
  endfunction

  always @(posedge Clk) cyc++;

  // RAM model: raises ram_mfc in the mfc_delay-th cycle of ram_mfa (0 = never)
  always @(posedge Clk) begin
    #1;
    if (bus.ram_mfa) begin
      mfa_run++;
      mfa_total++;
      if (mfa_run == 1) begin
        snap_rw   = bus.ram_rw;
        snap_addr = bus.ram_addr;
        snap_size = bus.ram_size;
        snap_din  = bus.ram_din;
      end
      mfc_r = (mfc_delay != 0) && (mfa_run == mfc_delay);
    end else begin
      mfa_run = 0;
      mfc_r   = 1'b0;
    end
  end

  // Completion monitor: every ack must match the head of the scoreboard
  always @(negedge Clk) begin
    if (reset) begin
      mfa_mark = mfa_total;
    end else if (bus.fetch_ack || bus.data_ack) begin
      ack_total++;
      check_val("single_ack", 64'(bus.fetch_ack & bus.data_ack), 64'd0);
      if (sb.size() == 0) begin
        check_val("spurious_ack", 64'(sb.size()), 64'd1);
      end else begin
        mon_e = sb.pop_front();
        check_val("ack_id", 64'(bus.data_ack), 64'(mon_e.id));
        check_val("ack_err", 64'(bus.data_ack ? bus.data_err : bus.fetch_err), 64'(mon_e.err));
        check_val("rdata", 64'(bus.rdata), 64'(mon_e.rdata));
        if (mon_e.lat >= 0) check_val("latency", 64'(cyc - mon_e.t0), 64'(mon_e.lat));
        check_val("mfa_cycles", 64'(mfa_total - mfa_mark), 64'(mon_e.mfa));
        if (mon_e.mfa > 0)
          check_val("ram_cmd", 64'({snap_rw, snap_addr, snap_size, snap_din}),
                    64'({mon_e.rw, mon_e.addr, mon_e.size, mon_e.din}));
      end
      mfa_mark = mfa_total;
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Wait for n acks, dropping each requester's req in its ack cycle
  task automatic wait_acks(input int n);
    int seen;
    int budget;
    seen   = 0;
    budget = 0;
    while (seen < n && budget < 100) begin
      @(negedge Clk);
      budget++;
      if (bus.fetch_ack) begin bus.fetch_req = 1'b0; seen++; end
      if (bus.data_ack)  begin bus.data_req  = 1'b0; seen++; end
    end
    if (seen < n) check_val("ack_wait", 64'(seen), 64'(n));
    tick();
  endtask

  task automatic txn(input logic id, input logic rw, input logic [8:0] addr,
                     input logic [1:0] size, input logic [31:0] wdata,
                     input int dly, input logic [31:0] dout);
    exp_t e;
    logic [1:0] sz;
    logic r;
    sz = id ? size : 2'b10;
    r  = id ? rw : 1'b1;
    mfc_delay = dly;
    dout_val  = dout;
    e.id   = id;
    e.t0   = cyc;
    e.rw   = r;
    e.addr = addr;
    e.size = sz;
    e.din  = id ? wdata : 32'h0;
    if (!is_legal(sz, addr)) begin
      e.err = 1'b1; e.lat = 1; e.mfa = 0;
    end else if (dly == 0) begin
      e.err = 1'b1; e.lat = TO + 1; e.mfa = TO;
    end else begin
      e.err = 1'b0; e.lat = dly + 1; e.mfa = dly;
      if (r) exp_rdata = dout;
    end
    e.rdata = exp_rdata;
    sb.push_back(e);
    if (id) begin
      bus.data_rw = rw; bus.data_addr = addr; bus.data_size = size;
      bus.data_wdata = wdata; bus.data_req = 1'b1;
    end else begin
      bus.fetch_addr = addr; bus.fetch_req = 1'b1;
    end
    wait_acks(1);
  endtask

  // Both requesters high together; first_id is the expected winner
  task automatic tie_pair(input logic first_id, input int dly, input logic [31:0] dout);
    exp_t e;
    int t;
    mfc_delay = dly;
    dout_val  = dout;
    bus.fetch_addr = 9'h020;
    bus.data_rw = 1'b1; bus.data_addr = 9'h040; bus.data_size = 2'b10; bus.data_wdata = 32'h0;
    bus.fetch_req = 1'b1;
    bus.data_req  = 1'b1;
    reset = 1'b0;
    t = cyc;
    exp_rdata = dout;
    for (int k = 0; k < 2; k++) begin
      e.id    = (k == 0) ? first_id : ~first_id;
      e.err   = 1'b0;
      e.rdata = dout;
      e.lat   = (k == 0) ? dly + 1 : 2 * dly + 3;
      e.t0    = t;
      e.mfa   = dly;
      e.rw    = 1'b1;
      e.addr  = e.id ? 9'h040 : 9'h020;
      e.size  = 2'b10;
      e.din   = 32'h0;
      sb.push_back(e);
    end
    wait_acks(2);
  endtask

  task automatic check_quiet(input string tag);
    check_val({tag, "_ctl"},
              64'({bus.busy, bus.ram_mfa, bus.ram_rw, bus.ram_addr, bus.ram_size,
                   bus.fetch_ack, bus.fetch_err, bus.data_ack, bus.data_err}), 64'd0);
    check_val({tag, "_din"}, 64'(bus.ram_din), 64'd0);
    check_val({tag, "_rdata"}, 64'(bus.rdata), 64'd0);
  endtask

  initial begin
    int acks_before;
    reset = 1'b1;
    bus.fetch_req = 1'b0; bus.fetch_addr = '0;
    bus.data_req = 1'b0; bus.data_rw = 1'b0; bus.data_addr = '0;
    bus.data_size = '0; bus.data_wdata = '0;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    check_quiet("reset");
    tick();
    reset = 1'b0;
    tick();

    // Single-requester traffic: legal, illegal and timeout cases
    txn(1'b0, 1'b1, 9'h010, 2'b10, 32'h0,        2, 32'hDEADBEEF);
    txn(1'b1, 1'b0, 9'h024, 2'b10, 32'h12345678, 1, 32'h0BAD0BAD);
    txn(1'b1, 1'b1, 9'h005, 2'b00, 32'h0,        3, 32'hA5A50011);
    txn(1'b1, 1'b1, 9'h002, 2'b01, 32'h0,        1, 32'h0000C0DE);
    txn(1'b1, 1'b0, 9'h003, 2'b01, 32'hFFFF0000, 1, 32'h11111111);
    txn(1'b1, 1'b1, 9'h004, 2'b11, 32'h0,        1, 32'h22222222);
    txn(1'b0, 1'b1, 9'h011, 2'b10, 32'h0,        1, 32'h33333333);
    txn(1'b1, 1'b1, 9'h006, 2'b10, 32'h0,        1, 32'h44444444);
    txn(1'b1, 1'b1, 9'h008, 2'b10, 32'h0,        0, 32'h55AA55AA);

    // Round-robin from reset: fetch wins first, then alternation
    reset = 1'b1;
    bus.fetch_req = 1'b1;
    bus.data_req  = 1'b1;
    tick();
    tick();
    exp_rdata = 32'h0;
    tie_pair(1'b0, 1, 32'hCAFE0001);
    tie_pair(1'b0, 1, 32'hCAFE0002);
    txn(1'b0, 1'b1, 9'h0FC, 2'b10, 32'h0, 1, 32'hCAFE0003);
    tie_pair(1'b1, 2, 32'hCAFE0004);

    // Reset during BUSY while ram_mfc is high aborts without an ack
    acks_before = ack_total;
    mfc_delay = 10;
    bus.fetch_addr = 9'h100;
    bus.fetch_req  = 1'b1;
    tick();
    bus.fetch_req = 1'b0;
    @(negedge Clk);
    check_val("abort_mfa_up", 64'(bus.ram_mfa), 64'd1);
    tick();
    @(negedge Clk);
    mfc_force = 1'b1;
    reset     = 1'b1;
    @(posedge Clk);
    #1;
    mfc_force = 1'b0;
    @(negedge Clk);
    check_quiet("abort");
    reset = 1'b0;
    exp_rdata = 32'h0;
    repeat (3) tick();
    check_val("abort_no_ack", 64'(ack_total), 64'(acks_before));

    txn(1'b1, 1'b0, 9'h0A0, 2'b10, 32'h87654321, 1, 32'h99999999);

    check_val("sb_drained", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 15, meaning max cycles in BUSY awaiting ram_mfc before abort (legal range 1..255).
REQ-002 SHALL have port Clk  input  1  system clock, all state changes on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset, sampled on Clk rising edge.
REQ-004 SHALL have port fetch_req  input  1  instruction-fetch request, always a word read.
REQ-005 SHALL have port fetch_addr  input  9  fetch byte address.
REQ-006 SHALL have ports fetch_ack / fetch_err  output  1 each  fetch completion pulse / error flag valid with ack.
REQ-007 SHALL have ports data_req  input  1, data_rw  input  1 (1=read, 0=write), data_addr  input  9, data_size  input  2 (00 byte, 01 half, 10 word, 11 reserved), data_wdata  input  32.
REQ-008 SHALL have ports data_ack / data_err  output  1 each  data completion pulse / error flag valid with ack.
REQ-009 SHALL have port rdata  output  32  read data, valid in the ack cycle of a successful read, held until next read completes.
REQ-010 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-011 SHALL have RAM-side ports ram_mfa  output  1, ram_rw  output  1 (1=read, 0=write), ram_addr  output  9, ram_size  output  2, ram_din  output  32, ram_dout  input  32, ram_mfc  input  1.

Function
REQ-012 SHALL implement FSM states IDLE, BUSY, DONE.
REQ-013 SHALL, in IDLE, sample fetch_req and data_req each cycle; with exactly one high, grant it; with both high, grant the requester not granted last (round-robin bit last_gnt).
REQ-014 SHALL, on grant, latch requester id, rw, addr, size, wdata into internal registers; later requester input changes do not affect the transaction.
REQ-015 SHALL check legality at grant: size 11, half with addr[0]=1, or word with addr[1:0]!=0 is illegal; illegal goes directly to DONE with err=1, no RAM access (ram_mfa stays 0).
REQ-016 SHALL, for a legal grant, enter BUSY next cycle with ram_mfa=1 and ram_rw/addr/size/din driven from latched values, stable for all of BUSY.
REQ-017 SHALL count BUSY cycles; on ram_mfc=1 latch ram_dout into rdata (reads only) and go to DONE with err=0.
REQ-018 SHALL, if TIMEOUT BUSY cycles elapse with ram_mfc=0, go to DONE with err=1, rdata unchanged.
REQ-019 SHALL, in DONE, drop ram_mfa to 0, pulse the granted requester's ack for exactly one cycle with its err, update last_gnt to that id, and return to IDLE.
REQ-020 SHALL drive ram_rw=1, ram_din=0 for fetches, and ram_size=10.
REQ-021 SHALL not pulse any ack outside DONE; at most one ack per cycle.
REQ-022 SHALL treat a req still high in the IDLE cycle after ack as a new transaction; requesters deassert req in the ack cycle to avoid repeats.
REQ-023 SHALL give latency: req in IDLE cycle 0 -> ram_mfa cycle 1 -> ram_mfc earliest cycle 1 -> ack cycle 2; illegal request ack cycle 1.
REQ-024 SHALL ignore ram_mfc outside BUSY.

Reset
REQ-025 SHALL, on reset=1 at a rising edge, enter IDLE, clear ram_mfa, ram_rw, ram_addr, ram_size, ram_din, rdata, all ack/err, busy, counter to 0, and set last_gnt=1 (fetch wins first tie).
REQ-026 SHALL abort any in-flight transaction on reset with no ack issued; reset has priority over ram_mfc in the same cycle.

Verification
REQ-027 SHALL cover: fetch_req addr 0x010, ram_mfc on 2nd BUSY cycle, ram_dout 0xDEADBEEF -> ram_mfa cycles 1-2, fetch_ack cycle 3, rdata 0xDEADBEEF, fetch_err 0.
REQ-028 SHALL cover: fetch_req and data_req both high from reset, each deasserted after ack, mfc immediate -> fetch granted first, then data; repeat both high -> alternation fetch, data, fetch.
REQ-029 SHALL cover: data write size 01 addr 0x003 -> data_ack cycle 1 with data_err 1, ram_mfa never asserted.
REQ-030 SHALL cover: data read, ram_mfc held 0, TIMEOUT=15 -> ram_mfa high 15 cycles, data_ack with data_err 1, rdata unchanged.
REQ-031 SHALL cover: reset asserted during BUSY with ram_mfc=1 same cycle -> IDLE next cycle, no ack, all outputs 0.
